// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and address constants for the OAM DMA arbiter.
// The echo remap folds 0xE0-0xFF source pages back onto work RAM.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR      = 16'hFF46;
    localparam logic [15:0] HI_REGION_BASE    = 16'hFF00;
    localparam logic [15:0] HI_REGION_LAST    = 16'hFFFE;
    localparam logic [7:0]  DMA_BLOCKED_RDATA = 8'hFF;
    localparam logic [7:0]  ECHO_BASE_HI      = 8'hE0;
    localparam logic [7:0]  ECHO_MASK         = 8'hDF;

    function automatic logic [7:0] echo_remap(input logic [7:0] hi);
        return (hi < ECHO_BASE_HI) ? hi : (hi & ECHO_MASK);
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU, external memory bus and OAM write port of the OAM DMA arbiter.
// slave = arbiter side, master = CPU/memory/OAM side.
interface oam_dma_arbiter_if;

    logic        m_cycle;
    logic        cpu_mem_enable;
    logic        cpu_mem_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [7:0]  cpu_hi_rdata;
    logic        bus_enable;
    logic        bus_write;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    modport slave (
        input  m_cycle, cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_wdata,
               cpu_hi_rdata, bus_rdata,
        output cpu_rdata, bus_enable, bus_write, bus_addr, bus_wdata,
               oam_we, oam_addr, oam_wdata, dma_active
    );

    modport master (
        output m_cycle, cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_wdata,
               cpu_hi_rdata, bus_rdata,
        input  cpu_rdata, bus_enable, bus_write, bus_addr, bus_wdata,
               oam_we, oam_addr, oam_wdata, dma_active
    );

endinterface

// File: rtl/oam_dma_arbiter_addr_decode.sv
// CPU address region decode: the DMA source register and the FF00-FFFE
// high region. The DMA register sits inside the high region; callers prioritise.
module dma_addr_decode
    import oam_dma_arbiter_pkg::*;
(
    input  logic [15:0] i_addr,
    output logic        o_is_dma_reg,
    output logic        o_is_hi_region
);

    assign o_is_dma_reg   = (i_addr == DMA_REG_ADDR);
    assign o_is_hi_region = (i_addr >= HI_REGION_BASE) && (i_addr <= HI_REGION_LAST);

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine plus CPU/DMA bus arbiter. A write to FF46 starts a
// DMA_LEN-byte copy from {src_hi,00} into OAM while locking the CPU out of the bus.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int DMA_LEN     = 160,
    parameter int START_DELAY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    oam_dma_arbiter_if.slave  io_bus
);

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [7:0] DELAY_LOAD = 8'(START_DELAY - 1);

    dma_state_e r_state;
    logic [7:0] r_index;
    logic [7:0] r_src_hi;
    logic [7:0] r_eff_hi;
    logic [7:0] r_delay;
    logic       r_active;

    logic        w_is_dma_reg;
    logic        w_is_hi;
    logic        w_trigger;
    logic        w_bus_enable;
    logic        w_bus_write;
    logic [15:0] w_bus_addr;
    logic [7:0]  w_bus_wdata;
    logic [7:0]  w_cpu_rdata;

    dma_addr_decode u_decode (
        .i_addr         (io_bus.cpu_addr),
        .o_is_dma_reg   (w_is_dma_reg),
        .o_is_hi_region (w_is_hi)
    );

    assign w_trigger = io_bus.m_cycle & io_bus.cpu_mem_enable &
                       io_bus.cpu_mem_write & w_is_dma_reg;

    // A trigger always wins, so a restart keeps r_active (and the old
    // r_eff_hi on the bus) until the new delay expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_src_hi <= '0;
            r_eff_hi <= '0;
            r_delay  <= '0;
            r_active <= 1'b0;
        end else if (io_bus.m_cycle) begin
            if (w_trigger) begin
                r_src_hi <= io_bus.cpu_wdata;
                r_state  <= START;
                r_delay  <= DELAY_LOAD;
            end else begin
                case (r_state)
                    START: begin
                        if (r_delay == '0) begin
                            r_state  <= XFER;
                            r_index  <= '0;
                            r_eff_hi <= echo_remap(r_src_hi);
                            r_active <= 1'b1;
                        end else begin
                            r_delay <= r_delay - 8'd1;
                        end
                    end
                    XFER: begin
                        if (r_index == LAST_IDX) begin
                            r_state  <= IDLE;
                            r_index  <= '0;
                            r_active <= 1'b0;
                        end else begin
                            r_index <= r_index + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // DMA owns the bus whenever active; the CPU then only reaches the high
    // region through the separate hi-bus read path.
    always_comb begin
        w_bus_enable = 1'b0;
        w_bus_write  = 1'b0;
        w_bus_addr   = io_bus.cpu_addr;
        w_bus_wdata  = io_bus.cpu_wdata;
        w_cpu_rdata  = io_bus.bus_rdata;
        if (r_active) begin
            w_bus_enable = 1'b1;
            w_bus_addr   = {r_eff_hi, r_index};
            w_bus_wdata  = '0;
            w_cpu_rdata  = w_is_hi ? io_bus.cpu_hi_rdata : DMA_BLOCKED_RDATA;
        end else if (reset_n) begin
            w_bus_enable = io_bus.cpu_mem_enable & ~w_is_dma_reg;
            w_bus_write  = io_bus.cpu_mem_enable & io_bus.cpu_mem_write & ~w_is_dma_reg;
        end
        if (w_is_dma_reg) w_cpu_rdata = r_src_hi;
    end

    assign io_bus.bus_enable = w_bus_enable;
    assign io_bus.bus_write  = w_bus_write;
    assign io_bus.bus_addr   = w_bus_addr;
    assign io_bus.bus_wdata  = w_bus_wdata;
    assign io_bus.cpu_rdata  = w_cpu_rdata;
    assign io_bus.oam_we     = (r_state == XFER) & io_bus.m_cycle;
    assign io_bus.oam_addr   = r_index;
    assign io_bus.oam_wdata  = io_bus.bus_rdata;
    assign io_bus.dma_active = r_active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: expected OAM writes are queued when a
// transfer is started and popped by an independent monitor on every oam_we.
module tb_oam_dma_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    oam_dma_arbiter_if bif ();

    oam_dma_arbiter #(.DMA_LEN(160), .START_DELAY(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bif.slave)
    );

    // External memory content model: data is a fixed function of the address.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    assign bif.bus_rdata = mem_f(bif.bus_addr);

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  d;
        logic [15:0] ba;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   act_mc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_xfer(input logic [7:0] hi, input int first, input int last);
        for (int i = first; i <= last; i++)
            q.push_back('{a: 8'(i), d: mem_f({hi, 8'(i)}), ba: {hi, 8'(i)}});
    endtask

    // m_cycle: one clk high out of four, changing 2ns after posedge.
    initial begin
        bif.m_cycle = 1'b0;
        forever begin
            @(posedge clk);
            #2 bif.m_cycle = 1'b1;
            @(posedge clk);
            #2 bif.m_cycle = 1'b0;
            repeat (2) @(posedge clk);
        end
    end

    always @(negedge clk)
        if (reset_n === 1'b1 && bif.m_cycle === 1'b1 && bif.dma_active === 1'b1) act_mc++;

    always @(negedge clk) begin
        if (bif.oam_we !== 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL oam_unexpected: oam_we=%b oam_addr %0h, none expected", bif.oam_we, bif.oam_addr);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("oam_addr", bif.oam_addr, e.a);
                chk("oam_wdata", bif.oam_wdata, e.d);
                chk("dma_bus_addr", bif.bus_addr, e.ba);
                chk("dma_bus_write", bif.bus_write, 0);
            end
        end
    end

    task automatic mc_edge();
        do @(posedge clk); while (bif.m_cycle !== 1'b1);
        #1;
    endtask

    task automatic cpu_idle();
        bif.cpu_mem_enable = 1'b0;
        bif.cpu_mem_write  = 1'b0;
    endtask

    task automatic cpu_set(input logic wr, input logic [15:0] a, input logic [7:0] d);
        bif.cpu_mem_enable = 1'b1;
        bif.cpu_mem_write  = wr;
        bif.cpu_addr       = a;
        bif.cpu_wdata      = d;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_set(1'b1, a, d);
        mc_edge();
        cpu_idle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bif.dma_active !== 1'b0 && n < 400) begin
            mc_edge();
            n++;
        end
        chk("dma_finished_in_time", 32'(n < 400), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_idle();
        bif.cpu_addr     = '0;
        bif.cpu_wdata    = '0;
        bif.cpu_hi_rdata = 8'h3C;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        cpu_set(1'b1, 16'h8000, 8'h12);
        #20;
        chk("rst_bus_enable", bif.bus_enable, 0);
        chk("rst_bus_write", bif.bus_write, 0);
        chk("rst_oam_we", bif.oam_we, 0);
        chk("rst_dma_active", bif.dma_active, 0);
        cpu_idle();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // idle pass-through
        mc_edge();
        cpu_set(1'b0, 16'h8000, 8'h00);
        #2;
        chk("idle_rd_en", bif.bus_enable, 1);
        chk("idle_rd_addr", bif.bus_addr, 16'h8000);
        chk("idle_rdata", bif.cpu_rdata, 8'hAD);
        cpu_set(1'b1, 16'hC000, 8'h55);
        #2;
        chk("idle_wr_write", bif.bus_write, 1);
        chk("idle_wr_wdata", bif.bus_wdata, 8'h55);
        chk("idle_wr_addr", bif.bus_addr, 16'hC000);
        cpu_idle();

        // plain transfer from C1
        push_xfer(8'hC1, 0, 159);
        act_mc = 0;
        cpu_write(16'hFF46, 8'hC1);
        chk("a_start_inactive", bif.dma_active, 0);
        cpu_set(1'b0, 16'h8000, 8'h00);
        #2;
        chk("a_start_pass_en", bif.bus_enable, 1);
        chk("a_start_pass_addr", bif.bus_addr, 16'h8000);
        chk("a_start_pass_rdata", bif.cpu_rdata, 8'hAD);
        cpu_idle();
        mc_edge();
        chk("a_xfer_active", bif.dma_active, 1);
        repeat (20) mc_edge();
        cpu_set(1'b0, 16'hFF46, 8'h00);
        #2;
        chk("a_reg_rd_during", bif.cpu_rdata, 8'hC1);
        chk("a_reg_rd_bus_hi", bif.bus_addr[15:8], 8'hC1);
        cpu_idle();
        wait_idle();
        chk("a_active_mcycles", act_mc, 160);
        chk("a_queue_drained", q.size(), 0);
        cpu_set(1'b0, 16'hFF46, 8'h00);
        #2;
        chk("a_reg_rd_after", bif.cpu_rdata, 8'hC1);
        chk("a_reg_rd_no_bus", bif.bus_enable, 0);
        cpu_idle();

        // echo remap E3 -> C3, with CPU accesses during the transfer
        push_xfer(8'hC3, 0, 159);
        cpu_write(16'hFF46, 8'hE3);
        mc_edge();
        repeat (10) mc_edge();
        cpu_set(1'b0, 16'h8000, 8'h00);
        #2;
        chk("c_blk_rdata", bif.cpu_rdata, 8'hFF);
        chk("c_blk_bus_hi", bif.bus_addr[15:8], 8'hC3);
        chk("c_blk_bus_en", bif.bus_enable, 1);
        cpu_set(1'b1, 16'hC000, 8'h77);
        #2;
        chk("c_wr_dropped", bif.bus_write, 0);
        chk("c_wr_bus_hi", bif.bus_addr[15:8], 8'hC3);
        cpu_set(1'b0, 16'hFF80, 8'h00);
        #2;
        chk("c_hram_rdata", bif.cpu_rdata, 8'h3C);
        cpu_set(1'b0, 16'hFFFF, 8'h00);
        #2;
        chk("c_ffff_blocked", bif.cpu_rdata, 8'hFF);
        cpu_idle();
        wait_idle();
        chk("b_queue_drained", q.size(), 0);

        // retrigger with D0 on the M-cycle that writes index 50
        push_xfer(8'hC1, 0, 50);
        push_xfer(8'hD0, 0, 159);
        cpu_write(16'hFF46, 8'hC1);
        mc_edge();
        repeat (50) mc_edge();
        cpu_write(16'hFF46, 8'hD0);
        chk("d_restart_active", bif.dma_active, 1);
        chk("d_restart_old_hi", bif.bus_addr[15:8], 8'hC1);
        cpu_set(1'b0, 16'h8000, 8'h00);
        #2;
        chk("d_restart_blocked", bif.cpu_rdata, 8'hFF);
        cpu_idle();
        wait_idle();
        chk("d_queue_drained", q.size(), 0);

        // reset while index 80 is being transferred
        push_xfer(8'h40, 0, 79);
        cpu_write(16'hFF46, 8'h40);
        mc_edge();
        repeat (80) mc_edge();
        wait (bif.m_cycle == 1'b0);
        wait (bif.m_cycle == 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("e_rst_oam_we", bif.oam_we, 0);
        chk("e_rst_active", bif.dma_active, 0);
        chk("e_rst_bus_en", bif.bus_enable, 0);
        cpu_write(16'hFF46, 8'h99);
        chk("e_queue_drained", q.size(), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cpu_set(1'b0, 16'hFF46, 8'h00);
        #2;
        chk("e_src_hi_cleared", bif.cpu_rdata, 8'h00);
        cpu_idle();
        repeat (5) mc_edge();
        chk("e_still_idle", bif.dma_active, 0);
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
